// File: rtl/cache_access_monitor_if.sv
// Response and miss-drain bus of the cache access monitor.
// Both channels use one rule: a beat transfers on a rising clk_i edge where valid and ready are both 1.
// Valid may not depend on ready.
// The response channel has no ready; the monitor always takes resp_valid_i.
interface cache_access_monitor_if #(
    parameter int PA_W = 16
);
    logic            resp_valid_i;
    logic            hit_i;
    logic [PA_W-1:0] pa_i;
    logic            miss_valid_o;
    logic [PA_W-1:0] miss_pa_o;
    logic            miss_ready_i;

    // Cache / consumer side.
    modport master (
        output resp_valid_i, hit_i, pa_i, miss_ready_i,
        input  miss_valid_o, miss_pa_o
    );

    // Monitor side.
    modport slave (
        input  resp_valid_i, hit_i, pa_i, miss_ready_i,
        output miss_valid_o, miss_pa_o
    );
endinterface

// File: rtl/cache_access_monitor.sv
// Windowed cache hit/miss statistics with a first-word-fall-through miss-address FIFO.
// Optional feature macro: CACHE_MON_STREAK_EN adds max_miss_streak_o (longest run of misses).
module cache_access_monitor #(
    parameter int PA_W            = 16,
    parameter int CNT_W           = 16,
    parameter int TOTAL_ACCESSES  = 4096,
    parameter int MISS_FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    cache_access_monitor_if.slave bus,
    output logic [CNT_W-1:0]      access_cnt_o,
    output logic [CNT_W-1:0]      hit_cnt_o,
    output logic [CNT_W-1:0]      miss_cnt_o,
    output logic                  overflow_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            state_o
`ifdef CACHE_MON_STREAK_EN
    ,
    output logic [CNT_W-1:0]      max_miss_streak_o
`endif
);

    localparam int ACC_W = $clog2(TOTAL_ACCESSES + 1);
    localparam int PTR_W = $clog2(MISS_FIFO_DEPTH);

    localparam logic [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
    localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(TOTAL_ACCESSES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(MISS_FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [ACC_W-1:0] acc_idx;
    logic             accept;
    logic             last_acc;
    logic             win_restart;

    logic [PA_W-1:0]  mem [MISS_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occ;
    logic             fifo_full;
    logic             push_req, push, pop, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // clear_i masks both window restart and response acceptance.
    assign accept      = bus.resp_valid_i && (state == S_RUN) && !clear_i;
    assign last_acc    = accept && (acc_idx == ACC_LAST);
    assign win_restart = start_i && !clear_i && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clear_i) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_i)  state_n = S_RUN;
                S_RUN:   if (last_acc) state_n = S_DONE;
                S_DONE:  if (start_i)  state_n = S_RUN;
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign busy_o  = (state == S_RUN);
    assign done_o  = (state == S_DONE);
    assign state_o = state;

    // The window length counter never saturates, so the window always ends on time.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_idx      <= '0;
            access_cnt_o <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else if (clear_i || win_restart) begin
            acc_idx      <= '0;
            access_cnt_o <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else if (accept) begin
            acc_idx      <= acc_idx + ACC_ONE;
            access_cnt_o <= sat_inc(access_cnt_o);
            if (bus.hit_i) hit_cnt_o  <= sat_inc(hit_cnt_o);
            else           miss_cnt_o <= sat_inc(miss_cnt_o);
        end
    end

    assign fifo_full        = (occ == OCC_FULL);
    assign bus.miss_valid_o = (occ != '0);
    assign pop              = bus.miss_valid_o && bus.miss_ready_i;
    assign push_req         = accept && !bus.hit_i;
    assign push             = push_req && (!fifo_full || pop);
    assign drop             = push_req && fifo_full && !pop;
    assign bus.miss_pa_o    = bus.miss_valid_o ? mem[rd_ptr] : '0;

    // FIFO contents need no reset: the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.pa_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      occ <= occ + OCC_ONE;
            else if (pop && !push) occ <= occ - OCC_ONE;
            if (drop) overflow_o <= 1'b1;
        end
    end

`ifdef CACHE_MON_STREAK_EN
    logic [CNT_W-1:0] cur_streak, max_streak, cur_streak_inc;

    assign cur_streak_inc    = sat_inc(cur_streak);
    assign max_miss_streak_o = max_streak;

    // Only accepted responses touch the run; idle cycles neither break nor extend it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_streak <= '0;
            max_streak <= '0;
        end else if (clear_i || win_restart) begin
            cur_streak <= '0;
            max_streak <= '0;
        end else if (accept) begin
            if (bus.hit_i) begin
                cur_streak <= '0;
            end else begin
                cur_streak <= cur_streak_inc;
                if (cur_streak_inc > max_streak) max_streak <= cur_streak_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_access_monitor.sv
// Directed bench for cache_access_monitor: two instances (short window / narrow counters).
// Optional feature macro: CACHE_MON_STREAK_EN enables the miss-streak checks.
module tb_cache_access_monitor;

  localparam int PA_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, clear_a, start_b, clear_b;
  logic [15:0] acc_a, hit_a, miss_a;
  logic [3:0]  acc_b, hit_b, miss_b;
  logic        ovf_a, busy_a, done_a, ovf_b, busy_b, done_b;
  logic [1:0]  st_a, st_b;
`ifdef CACHE_MON_STREAK_EN
  logic [15:0] streak_a;
  logic [3:0]  streak_b;
`endif

  cache_access_monitor_if #(.PA_W(PA_W)) if_a ();
  cache_access_monitor_if #(.PA_W(PA_W)) if_b ();

  cache_access_monitor #(
    .PA_W(PA_W), .CNT_W(16), .TOTAL_ACCESSES(8), .MISS_FIFO_DEPTH(8)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .clear_i(clear_a), .bus(if_a),
    .access_cnt_o(acc_a), .hit_cnt_o(hit_a), .miss_cnt_o(miss_a),
    .overflow_o(ovf_a), .busy_o(busy_a), .done_o(done_a), .state_o(st_a)
`ifdef CACHE_MON_STREAK_EN
    , .max_miss_streak_o(streak_a)
`endif
  );

  cache_access_monitor #(
    .PA_W(PA_W), .CNT_W(4), .TOTAL_ACCESSES(20), .MISS_FIFO_DEPTH(8)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .clear_i(clear_b), .bus(if_b),
    .access_cnt_o(acc_b), .hit_cnt_o(hit_b), .miss_cnt_o(miss_b),
    .overflow_o(ovf_b), .busy_o(busy_b), .done_o(done_b), .state_o(st_b)
`ifdef CACHE_MON_STREAK_EN
    , .max_miss_streak_o(streak_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [PA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp_a(input logic hit, input logic [PA_W-1:0] pa);
    if_a.resp_valid_i = 1'b1;
    if_a.hit_i        = hit;
    if_a.pa_i         = pa;
    tick();
    if_a.resp_valid_i = 1'b0;
  endtask

  task automatic resp_b(input logic hit, input logic [PA_W-1:0] pa);
    if_b.resp_valid_i = 1'b1;
    if_b.hit_i        = hit;
    if_b.pa_i         = pa;
    tick();
    if_b.resp_valid_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]      hit_pat;
    logic [6:0]      streak_pat;
    logic [PA_W-1:0] exp_pa;
    int              hits_exp;

    rst_n = 1'b0;
    start_a = 1'b0; clear_a = 1'b0; start_b = 1'b0; clear_b = 1'b0;
    if_a.resp_valid_i = 1'b0; if_a.hit_i = 1'b0; if_a.pa_i = '0; if_a.miss_ready_i = 1'b0;
    if_b.resp_valid_i = 1'b0; if_b.hit_i = 1'b0; if_b.pa_i = '0; if_b.miss_ready_i = 1'b0;

    tick();
    check("rst_acc",   32'(acc_a), 0);
    check("rst_busy",  32'(busy_a), 0);
    check("rst_done",  32'(done_a), 0);
    check("rst_mvld",  32'(if_a.miss_valid_o), 0);
    check("rst_mpa",   32'(if_a.miss_pa_o), 0);
    check("rst_ovf",   32'(ovf_a), 0);
    check("rst_state", 32'(st_a), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Window of 8 with hit pattern 1,0,1,1,0,0,1,0 (bit i = response i).
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t2_busy", 32'(busy_a), 1);
    hit_pat  = 8'b0100_1101;
    hits_exp = 0;
    for (int i = 0; i < 8; i++) begin
      if (hit_pat[i]) hits_exp++;
      else            exp_q.push_back(16'h1000 + 16'(i));
      resp_a(hit_pat[i], 16'h1000 + 16'(i));
      check("t2_acc",  32'(acc_a), i + 1);
      check("t2_hit",  32'(hit_a), hits_exp);
      check("t2_done", 32'(done_a), (i == 7) ? 1 : 0);
    end
    check("t2_hit_total",  32'(hit_a), 4);
    check("t2_miss_total", 32'(miss_a), 4);
    check("t2_busy_end",   32'(busy_a), 0);
    resp_a(1'b0, 16'h1008);
    check("t2_ninth_acc",  32'(acc_a), 8);
    check("t2_ninth_miss", 32'(miss_a), 4);
    if_a.miss_ready_i = 1'b1;
    while (exp_q.size() > 0) begin
      exp_pa = exp_q.pop_front();
      check("t2_pop_vld", 32'(if_a.miss_valid_o), 1);
      check("t2_pop_pa",  32'(if_a.miss_pa_o), 32'(exp_pa));
      tick();
    end
    if_a.miss_ready_i = 1'b0;
    check("t2_empty_vld", 32'(if_a.miss_valid_o), 0);
    check("t2_empty_pa",  32'(if_a.miss_pa_o), 0);

    // Restart from DONE zeroes counters; then clear with a colliding response.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t4_restart_acc",  32'(acc_a), 0);
    check("t4_restart_busy", 32'(busy_a), 1);
    resp_a(1'b1, 16'h2000);
    resp_a(1'b0, 16'h2001);
    resp_a(1'b1, 16'h2002);
    check("t4_acc3",  32'(acc_a), 3);
    check("t4_head",  32'(if_a.miss_pa_o), 32'h2001);
    clear_a = 1'b1;
    resp_a(1'b0, 16'h2003);
    clear_a = 1'b0;
    check("t4_state", 32'(st_a), 0);
    check("t4_acc",   32'(acc_a), 0);
    check("t4_hit",   32'(hit_a), 0);
    check("t4_miss",  32'(miss_a), 0);
    check("t4_mvld",  32'(if_a.miss_valid_o), 0);
    tick();
    check("t4_acc_later", 32'(acc_a), 0);

`ifdef CACHE_MON_STREAK_EN
    // Pattern M,M,H,M,M,M,H (bit i = hit), then a final hit closes the window.
    start_a = 1'b1; tick(); start_a = 1'b0;
    streak_pat = 7'b100_0100;
    for (int i = 0; i < 7; i++) begin
      resp_a(streak_pat[i], 16'h5000 + 16'(i));
      tick();
    end
    check("t6_streak", 32'(streak_a), 3);
    resp_a(1'b1, 16'h5007);
    check("t6_done",        32'(done_a), 1);
    check("t6_streak_done", 32'(streak_a), 3);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t6_streak_restart", 32'(streak_a), 0);
    clear_a = 1'b1; tick(); clear_a = 1'b0;
`else
    streak_pat = '0;
`endif

    // Overflow: 10 misses into a depth-8 FIFO with no consumer.
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(16'h4000 + 16'(i));
      resp_b(1'b0, 16'h4000 + 16'(i));
      check("t3_miss", 32'(miss_b), i + 1);
      check("t3_ovf",  32'(ovf_b), (i >= 8) ? 1 : 0);
    end
    check("t3_acc10", 32'(acc_b), 10);
    // Pop and push together while full: occupancy must stay at 8.
    if_b.miss_ready_i = 1'b1;
    exp_pa = exp_q.pop_front();
    check("t3_head_full", 32'(if_b.miss_pa_o), 32'(exp_pa));
    exp_q.push_back(16'h400A);
    resp_b(1'b0, 16'h400A);
    check("t3_miss11", 32'(miss_b), 11);
    check("t3_ovf_sticky", 32'(ovf_b), 1);
    while (exp_q.size() > 0) begin
      exp_pa = exp_q.pop_front();
      check("t3_pop_vld", 32'(if_b.miss_valid_o), 1);
      check("t3_pop_pa",  32'(if_b.miss_pa_o), 32'(exp_pa));
      tick();
    end
    if_b.miss_ready_i = 1'b0;
    check("t3_empty_vld", 32'(if_b.miss_valid_o), 0);
    clear_b = 1'b1; tick(); clear_b = 1'b0;
    check("t3_clear_ovf",  32'(ovf_b), 0);
    check("t3_clear_miss", 32'(miss_b), 0);

    // Saturation: 4-bit counters, 20-access window, all hits.
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      resp_b(1'b1, 16'h6000 + 16'(i));
      check("t5_hit",  32'(hit_b), (i + 1 > 15) ? 15 : i + 1);
      check("t5_acc",  32'(acc_b), (i + 1 > 15) ? 15 : i + 1);
      check("t5_done", 32'(done_b), (i == 19) ? 1 : 0);
    end
    check("t5_miss", 32'(miss_b), 0);
    check("t5_busy", 32'(busy_b), 0);

    // Asynchronous reset in the middle of a window.
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    resp_a(1'b0, 16'h3003);
    check("t1_pre_acc",  32'(acc_a), 1);
    check("t1_pre_mvld", 32'(if_a.miss_valid_o), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_acc",   32'(acc_a), 0);
    check("t1_miss",  32'(miss_a), 0);
    check("t1_mvld",  32'(if_a.miss_valid_o), 0);
    check("t1_mpa",   32'(if_a.miss_pa_o), 0);
    check("t1_busy",  32'(busy_a), 0);
    check("t1_state", 32'(st_a), 0);
    check("t1_b_hit", 32'(hit_b), 0);
    check("t1_b_done", 32'(done_b), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_idle_after", 32'(st_a), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
